multidigit_counter: RTL and testbench

Parametrised N-digit counter chain, generalising the two-digit button counter to any digit count and radix.
- Per-digit step pulses, up/down direction, ripple carry/borrow between digits within one cycle.
- Per-digit upper limits captured from the live count.
- Zero/limit flags and an MSD overflow pulse.
- Sits between the input synchroniser/clock scaler and the display decode/shift stage; cnt_out feeds the decoder unchanged.

---
 rtl/multidigit_counter_pkg.sv | 38 +++
 rtl/multidigit_counter_digit.sv | 32 +++
 rtl/multidigit_counter.sv | 89 ++++++++
 tb/tb_multidigit_counter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multidigit_counter_pkg.sv
// Shared digit width, direction codes and the single-digit step function.
// Optional saturation (CNT_SATURATE_EN) lives in the top module.
package multidigit_counter_pkg;
  localparam int DIGIT_W = 4;
  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  typedef struct packed {
    logic               wrap;
    logic [DIGIT_W-1:0] nxt;
  } digit_res_t;

  // Value a digit would take if stepped; wrap flags a rollover into the next digit.
  function automatic digit_res_t next_digit(input logic [DIGIT_W-1:0] value,
                                            input logic [DIGIT_W-1:0] limit,
                                            input logic               up);
    digit_res_t r;
    r.wrap = 1'b0;
    r.nxt  = value;
    if (limit == '0) begin
      r.wrap = 1'b1;
      r.nxt  = '0;
    end else if (up == UP) begin
      if (value < limit) r.nxt = value + 1'b1;
      else begin
        r.wrap = 1'b1;
        r.nxt  = '0;
      end
    end else if (up == DOWN) begin
      if (value == '0) begin
        r.wrap = 1'b1;
        r.nxt  = limit;
      end else if (value > limit) r.nxt = limit;
      else r.nxt = value - 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/multidigit_counter_digit.sv
// One counter digit: register plus step/limit logic. wrap reports what a
// step would do this cycle, whether or not step is asserted.
module counter_digit
  import multidigit_counter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               up,
  input  logic [DIGIT_W-1:0] limit,
  input  logic               clear,
  output logic [DIGIT_W-1:0] next,
  output logic               wrap
);
  logic [DIGIT_W-1:0] cnt_q, cnt_d;
  digit_res_t         res;

  always_comb begin
    res   = next_digit(cnt_q, limit, up);
    wrap  = res.wrap;
    cnt_d = cnt_q;
    if (clear)     cnt_d = '0;
    else if (step) cnt_d = res.nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign next = cnt_q;
endmodule

// File: rtl/multidigit_counter.sv
// N-digit up/down counter chain with in-cycle ripple, capturable limits and
// flags. Define CNT_SATURATE_EN to add the sat_en port (clamp instead of wrap).
module multidigit_counter
  import multidigit_counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIGITS-1:0]         inc,
  input  logic                      up_down_sel,
  input  logic                      carry_en,
  input  logic                      max_en,
  input  logic                      capture_max,
  input  logic                      clear,
`ifdef CNT_SATURATE_EN
  input  logic                      sat_en,
`endif
  output logic [DIGIT_W*DIGITS-1:0] cnt_out,
  output logic [DIGIT_W*DIGITS-1:0] max_out,
  output logic                      at_zero,
  output logic                      at_max,
  output logic                      carry_out
);
  localparam logic [DIGIT_W-1:0] LIM_DEF = DIGIT_W'(RADIX - 1);

  logic [DIGITS-1:0][DIGIT_W-1:0] cnt, lim, max_q, max_d;
  logic [DIGITS-1:0]              wrap, step, step_raw;
  logic                           carry_q, carry_d, sat;

`ifdef CNT_SATURATE_EN
  assign sat = sat_en;
`else
  assign sat = 1'b0;
`endif

  // Ripple resolves within the cycle; an own pulse and an incoming ripple
  // OR together into a single step.
  always_comb begin : ripple_chain
    logic rip;
    rip      = 1'b0;
    step_raw = '0;
    for (int j = 0; j < DIGITS; j++) begin
      step_raw[j] = inc[j] | (carry_en & rip);
      rip         = step_raw[j] & wrap[j];
    end
    step = step_raw;
    if (sat) begin
      if (carry_en) begin
        if (step_raw[DIGITS-1] & wrap[DIGITS-1]) step = '0;
      end else begin
        step = step_raw & ~wrap;
      end
    end
    carry_d = ~clear & ~sat & step_raw[DIGITS-1] & wrap[DIGITS-1];
    max_d   = capture_max ? cnt : max_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q   <= {DIGITS{LIM_DEF}};
      carry_q <= 1'b0;
    end else begin
      max_q   <= max_d;
      carry_q <= carry_d;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign lim[g] = max_en ? max_q[g] : LIM_DEF;
    counter_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .step  (step[g]),
      .up    (up_down_sel),
      .limit (lim[g]),
      .clear (clear),
      .next  (cnt[g]),
      .wrap  (wrap[g])
    );
  end

  assign cnt_out   = cnt;
  assign max_out   = max_q;
  assign carry_out = carry_q;
  assign at_zero   = (cnt == '0);
  assign at_max    = (cnt == lim);
endmodule

// File: tb/tb_multidigit_counter.sv
// Self-checking bench for multidigit_counter (DIGITS=2, RADIX=10) against a
// digit-array reference model plus directed scenarios.
module tb_multidigit_counter;
  localparam int D = 2;
  localparam int R = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic [D-1:0]   inc;
  logic           up_down_sel, carry_en, max_en, capture_max, clear;
  logic [4*D-1:0] cnt_out, max_out;
  logic           at_zero, at_max, carry_out;
`ifdef CNT_SATURATE_EN
  logic           sat_en = 1'b0;
`endif

  multidigit_counter #(.DIGITS(D), .RADIX(R)) dut (
    .clk         (clk),
    .reset       (reset),
    .inc         (inc),
    .up_down_sel (up_down_sel),
    .carry_en    (carry_en),
    .max_en      (max_en),
    .capture_max (capture_max),
    .clear       (clear),
`ifdef CNT_SATURATE_EN
    .sat_en      (sat_en),
`endif
    .cnt_out     (cnt_out),
    .max_out     (max_out),
    .at_zero     (at_zero),
    .at_max      (at_max),
    .carry_out   (carry_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integer digits.
  int m_cnt [D];
  int m_max [D];
  bit m_carry;

  function automatic logic [4*D-1:0] pack(input int sel);
    logic [4*D-1:0] v;
    for (int j = 0; j < D; j++) v[4*j +: 4] = 4'(sel ? m_max[j] : m_cnt[j]);
    return v;
  endfunction

  function automatic bit m_at_zero();
    for (int j = 0; j < D; j++) if (m_cnt[j] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_at_max();
    for (int j = 0; j < D; j++)
      if (m_cnt[j] != (max_en ? m_max[j] : R - 1)) return 1'b0;
    return 1'b1;
  endfunction

  // Apply one clock of the behavioural rules using the current inputs.
  task automatic model_edge();
    int old_c [D];
    int old_m [D];
    int lim, nx;
    bit s, w, rip;
    for (int j = 0; j < D; j++) begin
      old_c[j] = m_cnt[j];
      old_m[j] = m_max[j];
    end
    if (reset) begin
      for (int j = 0; j < D; j++) begin
        m_cnt[j] = 0;
        m_max[j] = R - 1;
      end
      m_carry = 0;
      return;
    end
    if (capture_max) for (int j = 0; j < D; j++) m_max[j] = old_c[j];
    if (clear) begin
      for (int j = 0; j < D; j++) m_cnt[j] = 0;
      m_carry = 0;
      return;
    end
    rip = 0;
    s = 0;
    w = 0;
    for (int j = 0; j < D; j++) begin
      s   = inc[j] | (carry_en & rip);
      lim = max_en ? old_m[j] : R - 1;
      w   = 0;
      nx  = old_c[j];
      if (lim == 0) begin
        nx = 0;
        w  = 1;
      end else if (up_down_sel) begin
        if (old_c[j] < lim) nx = old_c[j] + 1;
        else begin
          nx = 0;
          w  = 1;
        end
      end else begin
        if (old_c[j] == 0) begin
          nx = lim;
          w  = 1;
        end else if (old_c[j] > lim) nx = lim;
        else nx = old_c[j] - 1;
      end
      if (s) m_cnt[j] = nx;
      w   = s & w;
      rip = w;
    end
    m_carry = w;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [D-1:0] v);
    inc = v;
    tick();
    inc = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    inc = 2'b11; up_down_sel = 1; carry_en = 1; max_en = 0; capture_max = 0; clear = 0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    inc = '0;
    checks++;
    if (cnt_out !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h want 00", cnt_out); end
    checks++;
    if (max_out !== 8'h99) begin errors++; $display("FAIL reset_max got %h want 99", max_out); end
    checks++;
    if ({carry_out, at_zero, at_max} !== 3'b010)
      begin errors++; $display("FAIL reset_flags got %b want 010", {carry_out, at_zero, at_max}); end
  endtask

  task automatic test_count_up();
    do_reset();
    up_down_sel = 1; carry_en = 1; max_en = 0;
    for (int i = 0; i < 99; i++) pulse(2'b01);
    checks++;
    if (cnt_out !== 8'h99 || at_max !== 1'b1)
      begin errors++; $display("FAIL up_99 got %h/%b want 99/1", cnt_out, at_max); end
    pulse(2'b01);
    checks++;
    if (cnt_out !== 8'h00 || carry_out !== 1'b1 || at_zero !== 1'b1)
      begin errors++; $display("FAIL up_rollover got %h c=%b z=%b want 00 c=1 z=1", cnt_out, carry_out, at_zero); end
    tick();
    checks++;
    if (carry_out !== 1'b0) begin errors++; $display("FAIL carry_width got %b want 0", carry_out); end
  endtask

  task automatic test_capture_limit();
    do_reset();
    up_down_sel = 1; carry_en = 1; max_en = 0;
    for (int i = 0; i < 23; i++) pulse(2'b01);
    capture_max = 1;
    tick();
    capture_max = 0;
    checks++;
    if (max_out !== 8'h23) begin errors++; $display("FAIL capture got %h want 23", max_out); end
    max_en = 1;
    pulse(2'b01);
    checks++;
    if (cnt_out !== 8'h00 || carry_out !== 1'b1)
      begin errors++; $display("FAIL limit_rollover got %h c=%b want 00 c=1", cnt_out, carry_out); end
    for (int i = 0; i < 19; i++) begin
      pulse(2'b01);
      checks++;
      if (cnt_out !== pack(0) || cnt_out[3:0] > 4'd3)
        begin errors++; $display("FAIL limit_cycle got %h want %h", cnt_out, pack(0)); end
    end
    max_en = 0;
  endtask

  task automatic test_down();
    do_reset();
    up_down_sel = 0; carry_en = 1; max_en = 0;
    pulse(2'b01);
    checks++;
    if (cnt_out !== 8'h99 || carry_out !== 1'b1)
      begin errors++; $display("FAIL down_ripple got %h c=%b want 99 c=1", cnt_out, carry_out); end
    do_reset();
    carry_en = 0;
    pulse(2'b01);
    checks++;
    if (cnt_out !== 8'h09 || carry_out !== 1'b0)
      begin errors++; $display("FAIL down_noripple got %h c=%b want 09 c=0", cnt_out, carry_out); end
    up_down_sel = 1;
  endtask

  task automatic test_coincident();
    do_reset();
    up_down_sel = 1; carry_en = 1; max_en = 0;
    for (int i = 0; i < 9; i++) pulse(2'b01);
    pulse(2'b11);
    checks++;
    if (cnt_out !== 8'h10) begin errors++; $display("FAIL coincident got %h want 10", cnt_out); end
  endtask

  task automatic test_clear_capture();
    do_reset();
    up_down_sel = 1; carry_en = 1; max_en = 0;
    for (int i = 0; i < 45; i++) pulse(2'b01);
    clear = 1; capture_max = 1;
    pulse(2'b01);
    clear = 0; capture_max = 0;
    checks++;
    if (cnt_out !== 8'h00 || carry_out !== 1'b0 || max_out !== 8'h45)
      begin errors++; $display("FAIL clear_capture got %h c=%b max=%h want 00 c=0 max=45", cnt_out, carry_out, max_out); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 60) == 0);
      clear       = ($urandom_range(0, 25) == 0);
      capture_max = ($urandom_range(0, 15) == 0);
      inc         = D'($urandom) & D'($urandom);
      if ($urandom_range(0, 20) == 0) up_down_sel = ~up_down_sel;
      if ($urandom_range(0, 30) == 0) max_en = ~max_en;
      if ($urandom_range(0, 15) == 0) carry_en = ~carry_en;
      tick();
      checks++;
      if (cnt_out !== pack(0) || max_out !== pack(1) || carry_out !== m_carry ||
          at_zero !== m_at_zero() || at_max !== m_at_max())
        begin
          errors++;
          $display("FAIL random[%0d] got cnt=%h max=%h c=%b z=%b m=%b want cnt=%h max=%h c=%b z=%b m=%b",
                   i, cnt_out, max_out, carry_out, at_zero, at_max,
                   pack(0), pack(1), m_carry, m_at_zero(), m_at_max());
        end
    end
    reset = 0; clear = 0; capture_max = 0; inc = '0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_capture_limit();
    test_down();
    test_coincident();
    test_clear_capture();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
